// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the flash ROM controller port between master 0
// (instruction fetch) and master 1 (data/loader). Reads are granted
// round-robin and the request is latched for the whole ROM access. Writes
// are acknowledged locally with a wr_err pulse; the ROM never sees them.
`timescale 1ns/1ps

module rom_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    // master 0: instruction fetch
    input  logic        m0_en,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [20:0] m0_addr,
    output logic [31:0] m0_data_out,
    output logic        m0_wt,
    // master 1: data / loader
    input  logic        m1_en,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [20:0] m1_addr,
    output logic [31:0] m1_data_out,
    output logic        m1_wt,
    // local write acknowledge indicator
    output logic        wr_err,
    // ROM controller side
    output logic        rom_en,
    output logic        rom_wr,
    output logic [1:0]  rom_size,
    output logic [20:0] rom_addr,
    input  logic [31:0] rom_data_out,
    input  logic        rom_wt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_reg;
    logic        owner_reg;
    logic        last_reg;
    logic [1:0]  size_reg;
    logic [20:0] addr_reg;
    logic [1:0]  wack_reg;

    // per-master views of the ports so the master logic can be generated
    logic [1:0]  en_vec;
    logic [1:0]  wr_vec;
    logic [1:0]  size_arr [2];
    logic [20:0] addr_arr [2];
    logic [31:0] data_arr [2];
    logic [1:0]  wt_vec;
    logic [1:0]  rd_req;
    logic [1:0]  completing;

    logic        busy;
    logic        grant_valid;
    logic        grant_sel;

    assign en_vec      = {m1_en, m0_en};
    assign wr_vec      = {m1_wr, m0_wr};
    assign size_arr[0] = m0_size;
    assign size_arr[1] = m1_size;
    assign addr_arr[0] = m0_addr;
    assign addr_arr[1] = m1_addr;

    assign m0_data_out = data_arr[0];
    assign m1_data_out = data_arr[1];
    assign m0_wt       = wt_vec[0];
    assign m1_wt       = wt_vec[1];

    assign busy = (state_reg == BUSY);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            // A read is pending unless this master already holds the ROM
            // or is in the middle of a local write acknowledge.
            assign rd_req[gi] = en_vec[gi] & ~wr_vec[gi] & ~wack_reg[gi]
                                & ~(busy && (owner_reg == 1'(gi)));

            // Completion is forwarded combinationally in the ROM's wt=0 cycle;
            // a master that dropped en still gets (and ignores) the pulse.
            assign completing[gi] = busy & (owner_reg == 1'(gi)) & ~rom_wt;

            assign wt_vec[gi]   = ~(completing[gi] | wack_reg[gi]);
            assign data_arr[gi] = completing[gi] ? rom_data_out : 32'h0;
        end
    endgenerate

    // Round-robin: a tie goes to the master that was not granted last.
    assign grant_valid = |rd_req;
    assign grant_sel   = (&rd_req) ? ~last_reg : rd_req[1];

    // ROM side is driven only from latched state so the controller sees a
    // stable request for the whole access; IDLE forces a one-cycle gap.
    assign rom_en   = busy;
    assign rom_wr   = 1'b0;
    assign rom_size = size_reg;
    assign rom_addr = addr_reg;
    assign wr_err   = |wack_reg;

    // Arbitration FSM: grant in IDLE, hold the latched request while BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            size_reg  <= 2'b00;
            addr_reg  <= 21'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        owner_reg <= grant_sel;
                        last_reg  <= grant_sel;
                        size_reg  <= size_arr[grant_sel];
                        addr_reg  <= addr_arr[grant_sel];
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!rom_wt) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Local write acknowledge: one-cycle flag per accepted write, in any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wack_reg <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wack_reg[i] <= ~wack_reg[i] & en_vec[i] & wr_vec[i];
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed scenarios plus two randomized masters,
// checked every cycle against a cycle-number transaction model of the
// arbiter and a behavioural flash ROM controller.
`timescale 1ns/1ps

module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_en, m0_wr, m1_en, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [20:0] m0_addr, m1_addr;
    logic [31:0] m0_data_out, m1_data_out;
    logic        m0_wt, m1_wt;
    logic        wr_err;
    logic        rom_en, rom_wr;
    logic [1:0]  rom_size;
    logic [20:0] rom_addr;
    logic [31:0] rom_data_out;
    logic        rom_wt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    rom_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_en        (m0_en),
        .m0_wr        (m0_wr),
        .m0_size      (m0_size),
        .m0_addr      (m0_addr),
        .m0_data_out  (m0_data_out),
        .m0_wt        (m0_wt),
        .m1_en        (m1_en),
        .m1_wr        (m1_wr),
        .m1_size      (m1_size),
        .m1_addr      (m1_addr),
        .m1_data_out  (m1_data_out),
        .m1_wt        (m1_wt),
        .wr_err       (wr_err),
        .rom_en       (rom_en),
        .rom_wr       (rom_wr),
        .rom_size     (rom_size),
        .rom_addr     (rom_addr),
        .rom_data_out (rom_data_out),
        .rom_wt       (rom_wt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // flash contents as 16-bit words; one word pinned for the directed case
    function automatic logic [15:0] flash16(input logic [19:0] h);
        logic [15:0] x;
        x = (h[15:0] * 16'h9E37) ^ {h[19:16], 12'h5A5};
        if (h == 20'h00081) x = 16'hBBAA;
        return x;
    endfunction

    // data the ROM controller returns for a given address and size
    function automatic logic [31:0] flash_read(input logic [20:0] a, input logic [1:0] sz);
        logic [15:0] d0, d1;
        d0 = flash16(a[20:1]);
        d1 = flash16(a[20:1] + 20'd1);
        if (sz[1])      return {d0[7:0], d0[15:8], d1[7:0], d1[15:8]};
        else if (sz[0]) return {16'h0, d0[7:0], d0[15:8]};
        else            return {24'h0, (a[0] ? d0[7:0] : d0[15:8])};
    endfunction

    // behavioural ROM controller: wt low 7 (byte/half) or 13 (word) cycles after en rises
    int rom_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     rom_cnt <= 0;
        else if (!rom_en) rom_cnt <= 0;
        else              rom_cnt <= rom_cnt + 1;
    end
    assign rom_wt       = !(rom_en && rom_cnt == (rom_size[1] ? 13 : 7));
    assign rom_data_out = rom_wt ? 32'hDEADBEEF : flash_read(rom_addr, rom_size);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_req(input int i, input logic en, input logic wr,
                           input logic [20:0] a, input logic [1:0] sz);
        if (i == 0) begin m0_en = en; m0_wr = wr; m0_addr = a; m0_size = sz; end
        else        begin m1_en = en; m1_wr = wr; m1_addr = a; m1_size = sz; end
    endtask

    function automatic logic get_wt(input int i);
        return (i == 0) ? m0_wt : m1_wt;
    endfunction

    function automatic logic [31:0] get_data(input int i);
        return (i == 0) ? m0_data_out : m1_data_out;
    endfunction

    // One master transaction; call just after a posedge, returns just after a posedge.
    task automatic xfer(input int i, input logic wr, input logic [20:0] a, input logic [1:0] sz,
                        input int chg_at, input logic [20:0] a2,
                        output int lat, output logic [31:0] rdata);
        int          start;
        bit          done;
        logic [31:0] exp;
        exp   = wr ? 32'h0 : flash_read(a, sz);
        set_req(i, 1'b1, wr, a, sz);
        start = cyc;
        done  = 0;
        lat   = -1;
        rdata = 32'h0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (get_wt(i) == 1'b0) begin
                done  = 1;
                lat   = cyc - start;
                rdata = get_data(i);
                check($sformatf("m%0d_data", i), rdata, exp);
            end else if (k == chg_at) begin
                @(posedge clk);
                #1;
                set_req(i, 1'b1, wr, a2, sz);
            end
        end
        if (!done) check($sformatf("m%0d_timeout", i), 32'h0, 32'h1);
        @(posedge clk);
        #1;
        set_req(i, 1'b0, 1'b0, a, sz);
        $display("m%0d %s addr=%h size=%0d data=%h latency=%0d",
                 i, wr ? "WR" : "RD", a, sz, rdata, lat);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rom_en"},   32'(rom_en),   32'h0);
        check({tag, "_rom_wr"},   32'(rom_wr),   32'h0);
        check({tag, "_rom_size"}, 32'(rom_size), 32'h0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
        check({tag, "_m0_wt"},    32'(m0_wt),    32'h1);
        check({tag, "_m1_wt"},    32'(m1_wt),    32'h1);
        check({tag, "_m0_data"},  m0_data_out,   32'h0);
        check({tag, "_m1_data"},  m1_data_out,   32'h0);
        check({tag, "_wr_err"},   32'(wr_err),   32'h0);
    endtask

    // Reset pulse; call just after a posedge, returns just after a posedge.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_reset(tag);
        set_req(0, 1'b0, 1'b0, 21'h0, 2'b00);
        set_req(1, 1'b0, 1'b0, 21'h0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic rand_master(input int i, input int n);
        int          lat;
        logic [31:0] d;
        logic        wr;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            wr = ($urandom_range(0, 3) == 0);
            xfer(i, wr, 21'($urandom), 2'($urandom), -1, 21'h0, lat, d);
            if (wr) check($sformatf("m%0d_wr_latency", i), 32'(lat), 32'd1);
        end
    endtask

    // Reference model: tracks the access in cycle numbers. A read pending in
    // cycle c with the ROM free is granted at the end of c, completes in cycle
    // c+8 (byte/half) or c+14 (word), and the ROM is free again one cycle later.
    initial begin
        int          owner, last, gc, ge, free_at;
        int          wack [2];
        logic [20:0] la;
        logic [1:0]  ls;
        bit          active, cmp, wa, wa0, wa1, r0, r1;
        int          g;
        owner = -1; last = 1; gc = -1; ge = -1; free_at = 0;
        wack[0] = -1; wack[1] = -1; la = 21'h0; ls = 2'b00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                owner = -1; last = 1; gc = -1; ge = -1; free_at = 0;
                wack[0] = -1; wack[1] = -1; la = 21'h0; ls = 2'b00;
            end else begin
                active = (owner >= 0) && (cyc > gc) && (cyc <= ge);
                check("rom_en",   32'(rom_en),   32'(active));
                check("rom_wr",   32'(rom_wr),   32'h0);
                check("rom_addr", 32'(rom_addr), 32'(la));
                check("rom_size", 32'(rom_size), 32'(ls));
                wa0 = (wack[0] == cyc);
                wa1 = (wack[1] == cyc);
                for (int i = 0; i < 2; i++) begin
                    cmp = (owner == i) && (cyc == ge);
                    wa  = (i == 0) ? wa0 : wa1;
                    check($sformatf("m%0d_wt", i), 32'(get_wt(i)), 32'(!(cmp || wa)));
                    check($sformatf("m%0d_dout", i), get_data(i),
                          cmp ? flash_read(la, ls) : 32'h0);
                end
                check("wr_err", 32'(wr_err), 32'(wa0 || wa1));
                if (m0_en && m0_wr && !wa0) wack[0] = cyc + 1;
                if (m1_en && m1_wr && !wa1) wack[1] = cyc + 1;
                if (cyc >= free_at) begin
                    r0 = m0_en && !m0_wr;
                    r1 = m1_en && !m1_wr;
                    if (r0 || r1) begin
                        g       = (r0 && r1) ? (1 - last) : (r0 ? 0 : 1);
                        owner   = g;
                        last    = g;
                        gc      = cyc;
                        la      = (g == 0) ? m0_addr : m1_addr;
                        ls      = (g == 0) ? m0_size : m1_size;
                        ge      = cyc + (ls[1] ? 14 : 8);
                        free_at = ge + 1;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          l0, l1, l2, l3, l4;
        logic [31:0] d0, d1;
        reset_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 21'h0, 2'b00);
        set_req(1, 1'b0, 1'b0, 21'h0, 2'b00);
        #1;
        check_reset("por");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // halfword read with known flash contents
        xfer(0, 1'b0, 21'h000102, 2'b01, -1, 21'h0, l0, d0);
        check("hw_latency", 32'(l0), 32'd8);
        check("hw_data",    d0,      32'h0000AABB);

        // simultaneous word reads after reset: m0 first, then one idle cycle, then m1
        pulse_reset("rst1");
        fork
            xfer(0, 1'b0, 21'h000400, 2'b10, -1, 21'h0, l0, d0);
            xfer(1, 1'b0, 21'h010A02, 2'b10, -1, 21'h0, l1, d1);
        join
        check("tie_m0_latency", 32'(l0), 32'd14);
        check("tie_m1_latency", 32'(l1), 32'd29);

        // m1 streams 2 reads while m0 streams 3: grants alternate m0,m1,m0,m1,m0
        fork
            begin
                xfer(0, 1'b0, 21'h000010, 2'b01, -1, 21'h0, l0, d0);
                xfer(0, 1'b0, 21'h000021, 2'b00, -1, 21'h0, l1, d0);
                xfer(0, 1'b0, 21'h000032, 2'b01, -1, 21'h0, l2, d0);
            end
            begin
                xfer(1, 1'b0, 21'h1F0004, 2'b01, -1, 21'h0, l3, d1);
                xfer(1, 1'b0, 21'h1F0107, 2'b00, -1, 21'h0, l4, d1);
            end
        join
        check("rr_m0_a", 32'(l0), 32'd8);
        check("rr_m0_b", 32'(l1), 32'd17);
        check("rr_m0_c", 32'(l2), 32'd17);
        check("rr_m1_a", 32'(l3), 32'd17);
        check("rr_m1_b", 32'(l4), 32'd17);

        // m1 write while m0 owns the ROM
        fork
            xfer(0, 1'b0, 21'h0ABCD0, 2'b10, -1, 21'h0, l0, d0);
            begin
                repeat (4) begin @(posedge clk); #1; end
                xfer(1, 1'b1, 21'h000200, 2'b10, -1, 21'h0, l1, d1);
            end
        join
        check("wr_during_busy_m0_latency", 32'(l0), 32'd14);
        check("wr_during_busy_m1_latency", 32'(l1), 32'd1);

        // address changes mid-access: data must follow the latched address
        xfer(0, 1'b0, 21'h00F00E, 2'b10, 3, 21'h155554, l0, d0);
        check("addr_hold_latency", 32'(l0), 32'd14);
        check("addr_hold_data",    d0,      flash_read(21'h00F00E, 2'b10));

        // reset mid-word-read, then a fresh read
        set_req(0, 1'b1, 1'b0, 21'h003300, 2'b10);
        repeat (5) begin @(posedge clk); #1; end
        #2;
        pulse_reset("rst_mid");
        xfer(0, 1'b0, 21'h000102, 2'b01, -1, 21'h0, l0, d0);
        check("post_rst_latency", 32'(l0), 32'd8);
        check("post_rst_data",    d0,      32'h0000AABB);

        // randomized concurrent traffic from both masters
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-master arbiter that shares the single flash ROM controller port (en/wr/size/addr/data_out/wt) between master 0 (instruction fetch) and master 1 (data/loader port). It grants reads round-robin, holds a stable, latched request on the ROM side for the whole access, and routes the completion back to the owner. Writes, which the ROM controller never completes, are acknowledged locally so a stray store cannot hang a master. It sits between the bus masters and the ROM controller.

## Interface
- No parameters. Address width is 21, data width is 32, size is 2.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m0_en, m1_en  in  1  master request; held high until the master samples its wt low
- m0_wr, m1_wr  in  1  1 = write; no ROM access is made
- m0_size, m1_size  in  2  1x = word, 01 = halfword, 00 = byte; passed through unchanged
- m0_addr, m1_addr  in  21  byte address
- m0_data_out, m1_data_out  out  32  read data; valid only in the cycle where the master's wt is 0
- m0_wt, m1_wt  out  1  1 = wait; 0 for exactly one cycle on completion
- wr_err  out  1  one-cycle pulse for each locally acknowledged write, from either master
- rom_en, rom_wr, rom_size, rom_addr  out  1/1/2/21  request to the ROM controller
- rom_data_out  in  32  ROM read data
- rom_wt  in  1  ROM completion; 0 for one cycle

## Operation
- States: IDLE and BUSY. Registers: owner, last (last granted master), latched size and latched address, and per-master write-ack flags wack0 and wack1.
- Read request for master i: mi_en=1, mi_wr=0, master i is not the owner, and wacki=0.
- IDLE behaviour:
  - With exactly one read pending, grant that master.
  - With two reads pending, grant the master that is not last.
  - On grant: owner, last, latched size and latched address are loaded, and the next state is BUSY.
- BUSY behaviour:
  - rom_en=1, rom_wr=0, and rom_size/rom_addr come from the latched registers, never from the live inputs.
  - When rom_wt=0:
    - m[owner]_wt=0 and m[owner]_data_out=rom_data_out, both combinational in that same cycle.
    - The next state is IDLE.
  - In IDLE, rom_en=0 always. This cycle gives the ROM time to return to its idle state before the next request.
- Non-owner outputs:
  - mi_data_out=0 whenever master i is not completing.
  - mi_wt=1 unless master i is completing a read or wacki=1.
- Writes:
  - If mi_en=1, mi_wr=1 and wacki=0 at an edge, set wacki=1.
  - The following edge clears wacki.
  - mi_wt = ~wacki, mi_data_out = 0, and wr_err=wack0|wack1.
  - Writes are accepted in any state, including while the other master owns the ROM. The ROM is never touched by a write.
- If a master drops en while it is owner, the ROM access still runs to completion. The completion pulse is still driven and ignored.
- Simultaneous events:
  - A write ack for one master can coincide with a read completion for the other. Both wt outputs are low in the same cycle.
  - wr_err is 1 if either write-ack flag is set.

## Timing
- Reset (async, reset_n=0):
  - State IDLE, owner=0, last=1 (so master 0 wins the first tie), wack0=wack1=0.
  - Outputs: rom_en=0, rom_wr=0, rom_size=0, rom_addr=0, m0_wt=m1_wt=1, all data_out=0, wr_err=0.
- Reset asserted mid-access: same values immediately. The ROM controller shares the reset and restarts.
- Grant latency: a read pending before edge E0 in IDLE is granted at E0, and rom_en is high from E0 to the edge after rom_wt=0.
- End-to-end read latency with the current ROM controller, counting from the grant edge E0 to the cycle in which the master's wt=0:
  - Byte/halfword: the cycle following E7.
  - Word: the cycle following E13.
- Back-to-back accesses: there is a minimum of one IDLE cycle between successive ROM accesses.
- Write latency: the write ack (wt=0) is in the cycle after the sampling edge.

## Test plan
- m0 halfword read at addr 0x000102, flash d=0xBBAA → m0_wt=0 after E7, m0_data_out=0x0000AABB, and m1_wt stays 1.
- m0 and m1 word reads asserted in the same cycle after reset → m0 is served first (14 cycles), then one IDLE cycle, then m1. rom_addr switches only at m1's grant.
- m1 holds a read continuously while m0 issues 3 consecutive reads → grants alternate m0, m1, m0, m1, m0. Neither master waits for more than one foreign access.
- m1 write while m0 owns the ROM → m1_wt=0 and wr_err=1 for exactly one cycle, rom_en/rom_addr are unchanged, and m0 completes normally.
- Change m0_addr during BUSY → rom_addr holds the latched value and the data corresponds to the original address.
- Pulse reset_n low mid-word-read → all outputs take their reset values asynchronously. A fresh m0 read after release completes correctly.
